// File: rtl/sr_muldiv_unit.sv
// sr_muldiv_unit: iterative RV32M multiply/divide unit for the schoolRISCV core.
// Optional last-result cache is compiled in when SR_MULDIV_LASTRESULT_EN is defined.
module sr_muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             stall
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0]    LAST_COUNT = CW'(N - 1);
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_INT    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, CALC = 2'd2, DONE = 2'd3} stateT;

  // Multiplier-LSB-first shift-add; accumulator is {partial high, remaining multiplier}.
  function automatic logic [2*WIDTH-1:0] mulStep(input logic [2*WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] mcand);
    logic [2*WIDTH-1:0] r;
    logic [WIDTH:0]     sum;
    r = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      sum = {1'b0, r[2*WIDTH-1:WIDTH]} + (r[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      r   = {sum, r[WIDTH-1:1]};
    end
    return r;
  endfunction

  // Restoring division; accumulator is {partial remainder, dividend shifting into quotient}.
  function automatic logic [2*WIDTH-1:0] divStep(input logic [2*WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] dvsr);
    logic [2*WIDTH-1:0] r;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    r = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial = {r[2*WIDTH-1:WIDTH], r[WIDTH-1]};
      diff  = trial - {1'b0, dvsr};
      if (!diff[WIDTH]) r = {diff[WIDTH-1:0], r[WIDTH-2:0], 1'b1};
      else              r = {trial[WIDTH-1:0], r[WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

  stateT              stateR, nextS;
  logic [2:0]         opR;
  logic [WIDTH-1:0]   aR, bR, opndR, resultR;
  logic [2*WIDTH-1:0] accR;
  logic [CW-1:0]      countR;
  logic               negR, busyR, doneR;

  logic               fastS, aNegS, bNegS;
  logic [WIDTH-1:0]   fastResS, aMagS, bMagS, calcResS;
  logic [2*WIDTH-1:0] stepS, prodS;

  assign aNegS = aR[WIDTH-1] & ((opR == OP_MULH) | (opR == OP_MULHSU) | (opR == OP_DIV) | (opR == OP_REM));
  assign bNegS = bR[WIDTH-1] & ((opR == OP_MULH) | (opR == OP_DIV) | (opR == OP_REM));
  assign aMagS = aNegS ? (ZERO - aR) : aR;
  assign bMagS = bNegS ? (ZERO - bR) : bR;

`ifdef SR_MULDIV_LASTRESULT_EN
  logic               lastValidR;
  logic [2:0]         lastOpR;
  logic [WIDTH-1:0]   lastAR, lastBR, lastResR;
  logic [2*WIDTH-1:0] lastProdR;
  logic               sameOperandsS;
  assign sameOperandsS = lastValidR & (a == lastAR) & (b == lastBR);
`endif

  // Fast-path detection on the live request (only meaningful in IDLE).
  always_comb begin
    fastS    = 1'b0;
    fastResS = ZERO;
    if (op[2] && (b == ZERO)) begin
      fastS    = 1'b1;
      fastResS = op[1] ? a : ALL_ONES;
    end else if (op[2] && !op[0] && (a == MIN_INT) && (b == ALL_ONES)) begin
      fastS    = 1'b1;
      fastResS = op[1] ? ZERO : MIN_INT;
`ifdef SR_MULDIV_LASTRESULT_EN
    end else if (sameOperandsS && (op == lastOpR)) begin
      fastS    = 1'b1;
      fastResS = lastResR;
    end else if (sameOperandsS && (op == OP_MUL) &&
                 ((lastOpR == OP_MULH) || (lastOpR == OP_MULHSU) || (lastOpR == OP_MULHU))) begin
      fastS    = 1'b1;
      fastResS = lastProdR[WIDTH-1:0];
`endif
    end else begin
      fastS    = 1'b0;
      fastResS = ZERO;
    end
  end

  // Final iteration step and sign-corrected result selection.
  always_comb begin
    stepS    = opR[2] ? divStep(accR, opndR) : mulStep(accR, opndR);
    prodS    = negR ? ({(2*WIDTH){1'b0}} - stepS) : stepS;
    calcResS = ZERO;
    case (opR)
      OP_MUL:                       calcResS = prodS[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calcResS = prodS[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              calcResS = negR ? (ZERO - stepS[WIDTH-1:0]) : stepS[WIDTH-1:0];
      OP_REM, OP_REMU:              calcResS = negR ? (ZERO - stepS[2*WIDTH-1:WIDTH]) : stepS[2*WIDTH-1:WIDTH];
      default:                      calcResS = ZERO;
    endcase
  end

  // Next-state logic; kill overrides every state.
  always_comb begin
    nextS = stateR;
    if (kill) begin
      nextS = IDLE;
    end else begin
      case (stateR)
        IDLE: begin
          if (start) nextS = fastS ? DONE : PREP;
          else       nextS = IDLE;
        end
        PREP: nextS = CALC;
        CALC: begin
          if (countR == LAST_COUNT) nextS = DONE;
          else                      nextS = CALC;
        end
        DONE:    nextS = IDLE;
        default: nextS = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateR <= IDLE;
    else     stateR <= nextS;
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opR     <= 3'd0;
      aR      <= ZERO;
      bR      <= ZERO;
      opndR   <= ZERO;
      accR    <= {(2*WIDTH){1'b0}};
      countR  <= {CW{1'b0}};
      negR    <= 1'b0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
      resultR <= ZERO;
    end else begin
      busyR   <= (nextS == PREP) || (nextS == CALC);
      doneR   <= (nextS == DONE);
      resultR <= ZERO;
      case (stateR)
        IDLE: begin
          if (start && !kill) begin
            opR <= op;
            aR  <= a;
            bR  <= b;
          end
          if (nextS == DONE) resultR <= fastResS;
        end
        PREP: begin
          negR   <= (opR == OP_REM) ? aNegS : (aNegS ^ bNegS);
          opndR  <= opR[2] ? bMagS : aMagS;
          accR   <= {ZERO, (opR[2] ? aMagS : bMagS)};
          countR <= {CW{1'b0}};
        end
        CALC: begin
          accR   <= stepS;
          countR <= countR + CW'(1);
          if (nextS == DONE) resultR <= calcResS;
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

`ifdef SR_MULDIV_LASTRESULT_EN
  // Last completed request; product kept so MUL can follow MULHx without recomputing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastValidR <= 1'b0;
      lastOpR    <= 3'd0;
      lastAR     <= ZERO;
      lastBR     <= ZERO;
      lastResR   <= ZERO;
      lastProdR  <= {(2*WIDTH){1'b0}};
    end else if (nextS == DONE) begin
      lastValidR <= 1'b1;
      if (stateR == IDLE) begin
        lastOpR  <= op;
        lastAR   <= a;
        lastBR   <= b;
        lastResR <= fastResS;
      end else begin
        lastOpR   <= opR;
        lastAR    <= aR;
        lastBR    <= bR;
        lastResR  <= calcResS;
        lastProdR <= prodS;
      end
    end
  end
`endif

  assign busy   = busyR;
  assign done   = doneR;
  assign result = resultR;
  assign stall  = busyR | (start & (stateR == IDLE) & ~fastS);

endmodule

// File: tb/tb_sr_muldiv_unit.sv
// Self-checking bench for sr_muldiv_unit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and completion cycles.
module tb_sr_muldiv_unit;
  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic        busy, done, stall;

  logic        start4;
  logic [2:0]  op4;
  logic [31:0] a4, b4, result4;
  logic        busy4, done4, stall4;

  int nCmp = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  sr_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .kill(kill),
    .busy(busy), .done(done), .result(result), .stall(stall));

  sr_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4), .kill(1'b0),
    .busy(busy4), .done(done4), .result(result4), .stall(stall4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] refResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0]        p;
    logic signed [63:0] sx, sy, ux, uy;
    logic signed [31:0] q;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(x) / $signed(y); return q;
      end
      3'd5: return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'h0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        q = $signed(x) % $signed(y); return q;
      end
      default: return (y == 32'h0) ? x : x % y;
    endcase
  endfunction

  // Model state: mT = cycles since the request was accepted (0 = idle), mLat = cycle of done.
  int          mT = 0;
  int          mLat = 1;
  logic [31:0] mExp = 32'h0;
  logic [2:0]  mOp = 3'd0;
  logic [31:0] mA = 32'h0, mB = 32'h0;
  logic        cValid = 1'b0;
  logic [2:0]  cOp = 3'd0;
  logic [31:0] cA = 32'h0, cB = 32'h0;

  function automatic logic refFast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic f;
    f = o[2] && (y == 32'h0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
`ifdef SR_MULDIV_LASTRESULT_EN
    if (cValid && x == cA && y == cB && (o == cOp || (o == 3'd0 && cOp >= 3'd1 && cOp <= 3'd3))) f = 1'b1;
`endif
    return f;
  endfunction

  always @(negedge clk) begin : cmp
    logic        expBusy, expDone, expStall;
    logic [31:0] expRes;
    if (rst) begin mT = 0; cValid = 1'b0; end
    expBusy  = (mT >= 1) && (mT < mLat);
    expDone  = (mT != 0) && (mT == mLat);
    expRes   = expDone ? mExp : 32'h0;
    expStall = expBusy || (start && mT == 0 && !refFast(op, a, b));
    check("busy", busy, expBusy);
    check("done", done, expDone);
    check("result", result, expRes);
    check("stall", stall, expStall);
    if (rst || kill) mT = 0;
    else if (mT == 0) begin
      if (start) begin
        mLat = refFast(op, a, b) ? 1 : N + 2;
        mExp = refResult(op, a, b);
        mOp = op; mA = a; mB = b;
        mT = 1;
      end
    end else if (mT == mLat) mT = 0;
    else mT++;
    if (mT != 0 && mT == mLat) begin
      cValid = 1'b1; cOp = mOp; cA = mA; cB = mB;
    end
  end

  task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int expCyc, input logic [31:0] expRes, input int injCyc);
    int          doneCyc;
    int          busyCnt;
    logic [31:0] got;
    doneCyc = -1; busyCnt = 0; got = 32'h0;
    @(posedge clk); #2;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    check({name, ".stall0"}, stall, (expCyc > 1) ? 1'b1 : 1'b0);
    for (int c = 1; c <= 80 && doneCyc < 0; c++) begin
      @(posedge clk); #2;
      start = (c == injCyc);
      if (c == injCyc) begin op = 3'd4; a = 32'd100; b = 32'd0; end
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin doneCyc = c; got = result; end
    end
    check({name, ".cycle"}, doneCyc, expCyc);
    check({name, ".result"}, got, expRes);
    check({name, ".busycnt"}, busyCnt, expCyc - 1);
  endtask

  task automatic abortRun(input logic useKill);
    int nDone;
    int nz;
    nDone = 0; nz = 0;
    @(posedge clk); #2;
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #2;
      start = 1'b0;
      if (useKill) kill = (c == 12);
      else         rst  = (c == 12);
      @(negedge clk);
      if (c > 12) begin
        if (done) nDone++;
        if (result != 32'h0) nz++;
      end
    end
    check(useKill ? "kill.nodone" : "rst.nodone", nDone, 0);
    check(useKill ? "kill.result0" : "rst.result0", nz, 0);
  endtask

  task automatic run4(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input int expCyc, input logic [31:0] expRes);
    int          doneCyc;
    logic [31:0] got;
    doneCyc = -1; got = 32'h0;
    @(posedge clk); #2;
    start4 = 1'b1; op4 = o; a4 = x; b4 = y;
    for (int c = 1; c <= 30 && doneCyc < 0; c++) begin
      @(posedge clk); #2;
      start4 = 1'b0;
      @(negedge clk);
      if (done4) begin doneCyc = c; got = result4; end
    end
    check({name, ".cycle"}, doneCyc, expCyc);
    check({name, ".result"}, got, expRes);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          d1, d2, nDone;
    logic [31:0] r1, r2;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
    start4 = 1'b0; op4 = 3'd0; a4 = 32'h0; b4 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.result", result, 32'h0);
    check("rst.stall", stall, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;

    runOp("mul_7_n3",      3'd0, 32'd7,          32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, 0);
    runOp("mulh_min",      3'd1, 32'h8000_0000,  32'h8000_0000, 34, 32'h4000_0000, 0);
    runOp("mulhu_min",     3'd3, 32'h8000_0000,  32'h8000_0000, 34, 32'h4000_0000, 0);
    runOp("mulhsu_min",    3'd2, 32'h8000_0000,  32'h8000_0000, 34, 32'hC000_0000, 0);
    runOp("mulhsu_m1",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, 0);
    runOp("mulh_m1",       3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'h0000_0000, 0);
    runOp("mulhu_max",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 0);
    runOp("div_n7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFD, 0);
    runOp("rem_n7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFF, 0);
    runOp("div_7_n2",      3'd4, 32'd7,          32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 0);
    runOp("rem_7_n2",      3'd6, 32'd7,          32'hFFFF_FFFE, 34, 32'h0000_0001, 0);
    runOp("divu_max_16",   3'd5, 32'hFFFF_FFFF,  32'h10,        34, 32'h0FFF_FFFF, 0);
    runOp("remu_100_7",    3'd7, 32'd100,        32'd7,         34, 32'd2,         0);
    runOp("div_5_0",       3'd4, 32'd5,          32'd0,         1,  32'hFFFF_FFFF, 0);
    runOp("rem_5_0",       3'd6, 32'd5,          32'd0,         1,  32'd5,         0);
    runOp("divu_5_0",      3'd5, 32'd5,          32'd0,         1,  32'hFFFF_FFFF, 0);
    runOp("remu_5_0",      3'd7, 32'd5,          32'd0,         1,  32'd5,         0);
    runOp("div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h8000_0000, 0);
    runOp("rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h0000_0000, 0);
    runOp("start_in_busy", 3'd0, 32'd5,          32'd6,         34, 32'd30,        5);

    abortRun(1'b0);
    abortRun(1'b1);
    runOp("mul_3_4", 3'd0, 32'd3, 32'd4, 34, 32'd12, 0);

    // kill together with start in IDLE drops the request
    nDone = 0;
    @(posedge clk); #2;
    start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #2;
      start = 1'b0; kill = 1'b0;
      @(negedge clk);
      if (done) nDone++;
    end
    check("kill_idle.nodone", nDone, 0);

    // back-to-back with start held high: second op accepted the cycle after DONE
    d1 = -1; d2 = -1; r1 = 32'h0; r2 = 32'h0;
    @(posedge clk); #2;
    start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
    for (int c = 1; c <= 80 && d2 < 0; c++) begin
      @(posedge clk); #2;
      if (c == 1) b = 32'd8;
      if (c == 36) start = 1'b0;
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin d1 = c; r1 = result; end
        else begin d2 = c; r2 = result; end
      end
    end
    start = 1'b0;
    check("b2b.cycle1", d1, 34);
    check("b2b.result1", r1, 32'd42);
    check("b2b.cycle2", d2, 69);
    check("b2b.result2", r2, 32'd48);

    run4("bpc4_mul", 3'd0, 32'h1234_5678, 32'h10, 10, 32'h2345_6780);
`ifdef SR_MULDIV_LASTRESULT_EN
    run4("bpc4_mul_repeat", 3'd0, 32'h1234_5678, 32'h10, 1, 32'h2345_6780);
`endif
    run4("bpc4_divu", 3'd5, 32'd100, 32'd7, 10, 32'd14);
    run4("bpc4_rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF);

`ifdef SR_MULDIV_LASTRESULT_EN
    runOp("mulh_7_n3",     3'd1, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFFF, 0);
    runOp("mul_from_mulh", 3'd0, 32'd7, 32'hFFFF_FFFD, 1,  32'hFFFF_FFEB, 0);
    runOp("mul_repeat",    3'd0, 32'd7, 32'hFFFF_FFFD, 1,  32'hFFFF_FFEB, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
